// File: rtl/display_pkg.sv
// Shared constants for the multiplexed 7-segment display path: glyphs, scan states, anode idle value.
package display_pkg;

  // Segment order is {g,f,e,d,c,b,a}. All values are active-low.
  localparam logic [6:0] SEG_0    = 7'b1000000;
  localparam logic [6:0] SEG_1    = 7'b1111001;
  localparam logic [6:0] SEG_2    = 7'b0100100;
  localparam logic [6:0] SEG_3    = 7'b0110000;
  localparam logic [6:0] SEG_4    = 7'b0011001;
  localparam logic [6:0] SEG_5    = 7'b0010010;
  localparam logic [6:0] SEG_6    = 7'b0000010;
  localparam logic [6:0] SEG_7    = 7'b1111000;
  localparam logic [6:0] SEG_8    = 7'b0000000;
  localparam logic [6:0] SEG_9    = 7'b0010000;
  localparam logic [6:0] SEG_DASH = 7'b0111111;
  localparam logic [6:0] SEG_OFF  = 7'b1111111;

  localparam logic [3:0] AN_OFF = 4'b1111;

  typedef enum logic [1:0] {
    D0 = 2'd0,
    D1 = 2'd1,
    D2 = 2'd2,
    D3 = 2'd3
  } scan_t;

endpackage

// File: rtl/bcd_a_7seg.sv
// Combinational BCD to active-low 7-segment glyph decoder; codes A-F show a dash.
module bcd_a_7seg
  import display_pkg::*;
(
  input  logic [3:0] digit,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_DASH;
    case (digit)
      4'd0: seg = SEG_0;
      4'd1: seg = SEG_1;
      4'd2: seg = SEG_2;
      4'd3: seg = SEG_3;
      4'd4: seg = SEG_4;
      4'd5: seg = SEG_5;
      4'd6: seg = SEG_6;
      4'd7: seg = SEG_7;
      4'd8: seg = SEG_8;
      4'd9: seg = SEG_9;
      default: seg = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/display_bcd_mux.sv
// 4-digit multiplexed 7-segment driver: per-frame input snapshot, leading-zero blanking,
// registered segment/anode/dp outputs and a frame boundary pulse.
module display_bcd_mux
  import display_pkg::*;
#(
  parameter int REFRESH_DIV = 50000,
  parameter int CNT_W       = 16,
  parameter bit BLANK_LZ    = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [11:0] sal,
  input  logic [3:0]  sal_aux,
  input  logic [3:0]  dp_sel,
  output logic [6:0]  seg,
  output logic [3:0]  an,
  output logic        dp,
  output logic        frame_tick
);

  localparam logic [CNT_W-1:0] TC_VAL = CNT_W'(REFRESH_DIV - 1);

  logic [CNT_W-1:0] cnt;
  scan_t            idx;
  scan_t            idx_next;
  logic [15:0]      snap;
  logic             load_pend;
  logic             tc;
  logic             boundary;
  logic [3:0]       dig;
  logic [6:0]       glyph;
  logic [3:0]       blank;

  // The scan is frozen while the post-reset load is pending so D0 gets a full dwell.
  assign tc       = (cnt == TC_VAL);
  assign boundary = !load_pend && tc && (idx == D3);

  always_comb begin
    idx_next = idx;
    if (!load_pend && tc) begin
      case (idx)
        D0:      idx_next = D1;
        D1:      idx_next = D2;
        D2:      idx_next = D3;
        default: idx_next = D0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      idx <= D0;
    end else begin
      idx <= idx_next;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt       <= '0;
      snap      <= '0;
      load_pend <= 1'b1;
    end else if (load_pend) begin
      snap      <= {sal_aux, sal};
      load_pend <= 1'b0;
    end else begin
      cnt <= tc ? '0 : cnt + 1'b1;
      if (boundary) begin
        snap <= {sal_aux, sal};
      end
    end
  end

  assign dig = snap[{idx, 2'b00} +: 4];

  bcd_a_7seg u_dec (
    .digit (dig),
    .seg   (glyph)
  );

  // A blank propagates rightwards only through zero codes; a dash is non-zero and stops it.
  always_comb begin
    blank    = 4'b0000;
    blank[3] = BLANK_LZ && (snap[15:12] == 4'd0);
    blank[2] = blank[3] && (snap[11:8] == 4'd0);
    blank[1] = blank[2] && (snap[7:4] == 4'd0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      an         <= AN_OFF;
      seg        <= SEG_OFF;
      dp         <= 1'b1;
      frame_tick <= 1'b0;
    end else begin
      frame_tick <= boundary;
      if (load_pend || blank[idx]) begin
        an  <= AN_OFF;
        seg <= SEG_OFF;
        dp  <= 1'b1;
      end else begin
        an  <= ~(4'b0001 << idx);
        seg <= glyph;
        dp  <= ~dp_sel[idx];
      end
    end
  end

endmodule

// File: tb/tb_display_bcd_mux.sv
// Bench for display_bcd_mux: directed scenarios plus random traffic, checked every cycle
// against a timeline model (edge count since snapshot load -> slot, frame, tick).
module tb_display_bcd_mux;

  localparam int R   = 4;
  localparam bit BLZ = 1'b1;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [11:0] sal = 12'h000;
  logic [3:0]  sal_aux = 4'h0;
  logic [3:0]  dp_sel = 4'h0;
  logic [6:0]  seg;
  logic [3:0]  an;
  logic        dp;
  logic        frame_tick;

  int compared   = 0;
  int mismatched = 0;

  // model state
  bit          pending  = 1'b1;
  int          n        = 0;
  int          cur_slot = -1;
  logic [15:0] m_snap   = 16'h0;
  logic [6:0]  e_seg;
  logic [3:0]  e_an;
  logic        e_dp;
  logic        e_ft;

  display_bcd_mux #(
    .REFRESH_DIV (R),
    .CNT_W       (2),
    .BLANK_LZ    (BLZ)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .sal        (sal),
    .sal_aux    (sal_aux),
    .dp_sel     (dp_sel),
    .seg        (seg),
    .an         (an),
    .dp         (dp),
    .frame_tick (frame_tick)
  );

  always #5 clk = ~clk;

  function automatic logic [6:0] glyph_of(input logic [3:0] d);
    case (d)
      4'd0: return 7'b1000000;
      4'd1: return 7'b1111001;
      4'd2: return 7'b0100100;
      4'd3: return 7'b0110000;
      4'd4: return 7'b0011001;
      4'd5: return 7'b0010010;
      4'd6: return 7'b0000010;
      4'd7: return 7'b1111000;
      4'd8: return 7'b0000000;
      4'd9: return 7'b0010000;
      default: return 7'b0111111;
    endcase
  endfunction

  // Expected outputs after the coming edge, from the inputs present at that edge.
  task automatic model_edge();
    int highest;
    logic [3:0] d;
    e_an = 4'b1111; e_seg = 7'b1111111; e_dp = 1'b1; e_ft = 1'b0;
    cur_slot = -1;
    if (rst) begin
      pending = 1'b1;
    end else if (pending) begin
      m_snap  = {sal_aux, sal};
      n       = 0;
      pending = 1'b0;
    end else begin
      n++;
      cur_slot = ((n - 1) / R) % 4;
      highest = 0;
      for (int i = 0; i < 4; i++) begin
        if (m_snap[i*4 +: 4] != 4'd0) highest = i;
      end
      if (!BLZ || cur_slot <= highest) begin
        d     = m_snap[cur_slot*4 +: 4];
        e_an  = ~(4'b0001 << cur_slot);
        e_seg = glyph_of(d);
        e_dp  = ~dp_sel[cur_slot];
      end
      if (n % (4 * R) == 0) begin
        e_ft   = 1'b1;
        m_snap = {sal_aux, sal};
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    compared++;
    assert (an === e_an) else begin
      mismatched++;
      $error("FAIL an: observed %b expected %b (n=%0d)", an, e_an, n);
    end
    compared++;
    assert (seg === e_seg) else begin
      mismatched++;
      $error("FAIL seg: observed %b expected %b (n=%0d)", seg, e_seg, n);
    end
    compared++;
    assert (dp === e_dp) else begin
      mismatched++;
      $error("FAIL dp: observed %b expected %b (n=%0d)", dp, e_dp, n);
    end
    compared++;
    assert (frame_tick === e_ft) else begin
      mismatched++;
      $error("FAIL frame_tick: observed %b expected %b (n=%0d)", frame_tick, e_ft, n);
    end
  endtask

  task automatic run(input int cycles);
    for (int i = 0; i < cycles; i++) step();
  endtask

  task automatic run_to_slot(input int s);
    int k;
    k = 0;
    while (cur_slot != s && k < 64) begin
      step();
      k++;
    end
    compared++;
    assert (cur_slot == s) else begin
      mismatched++;
      $error("FAIL run_to_slot: observed slot %0d expected %0d", cur_slot, s);
    end
  endtask

  initial begin
    // reset held with arbitrary inputs
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      sal = 12'($urandom); sal_aux = 4'($urandom); dp_sel = 4'($urandom);
      step();
    end
    // normal scan
    sal = 12'h123; sal_aux = 4'h0; dp_sel = 4'h0;
    rst = 1'b0;
    run(40);
    // tearing: change mid-frame while D1 is shown
    run_to_slot(1);
    sal = 12'h456;
    run(36);
    // leading zeros
    sal = 12'h005;
    run(36);
    sal = 12'h000;
    run(36);
    // invalid code in the leftmost digit
    sal_aux = 4'hA; sal = 12'h007;
    run(36);
    // decimal point and mid-scan reset during D2
    sal_aux = 4'h0; sal = 12'h123; dp_sel = 4'b0100;
    run(20);
    run_to_slot(2);
    rst = 1'b1;
    step();
    rst = 1'b0;
    run(36);
    // randomized traffic with occasional resets
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 19) == 0) begin
        sal = 12'($urandom);
        sal_aux = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom);
        if ($urandom_range(0, 2) == 0) sal[11:4] = 8'h00;
      end
      dp_sel = 4'($urandom);
      rst = ($urandom_range(0, 59) == 0);
      step();
    end
    rst = 1'b0;
    run(20);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
